// File: rtl/block_avg_scaler_if.sv
// Handshake and memory bus of the block-averaging downscaler.
// master: zoom controller plus the two frame RAMs; slave: block_avg_scaler.
interface block_avg_scaler_if #(
   parameter int DATA_W = 8,
   parameter int RD_AW  = 15,
   parameter int WR_AW  = 15
);
   logic              start;
   logic [1:0]        factor_log2;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [RD_AW-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [WR_AW-1:0]  wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output start, factor_log2, rd_data,
      input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  start, factor_log2, rd_data,
      output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/block_avg_scaler.sv
// block_avg_scaler: reads an IMG_W x IMG_H source image block by block
// (F x F blocks, F = 1, 2 or 4) from a synchronous-read RAM and writes one
// averaged pixel per block to the destination RAM in raster order.
// Optional build macro ROUND_NEAREST_EN: round-to-nearest instead of
// truncation when averaging (k > 0), with saturation to the pixel maximum.
module block_avg_scaler #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int RD_AW  = 15,
   parameter int WR_AW  = 15
) (
   input logic clk,
   input logic rst_n,
   block_avg_scaler_if.slave bus
);

   localparam int ACC_W = DATA_W + 4;
   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam logic [ACC_W:0] PIX_MAX = {{5{1'b0}}, {DATA_W{1'b1}}};

   typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

   state_t            state;
   logic [1:0]        k_q;
   logic [3:0]        rd_cnt;
   logic [1:0]        dx;
   logic [XW-1:0]     bx;
   logic [YW-1:0]     by;
   logic [RD_AW-1:0]  blk_base;
   logic [WR_AW-1:0]  out_idx;

   logic              busy_q, done_q, rd_en_q, wr_en_q;
   logic [RD_AW-1:0]  rd_addr_q;
   logic [WR_AW-1:0]  wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   logic              rd_vld_p1, first_p1;
   logic [ACC_W-1:0]  acc;

   logic [1:0]        f_m1;
   logic [3:0]        nsq_m1;
   logic [XW-1:0]     ow_m1;
   logic [YW-1:0]     oh_m1;
   logic [RD_AW-1:0]  row_wrap;
   logic [RD_AW-1:0]  next_base;
   logic [RD_AW-1:0]  next_rd;
   logic [ACC_W-1:0]  acc_in;
   logic              last_blk;

   // Clamp a rounded sum to the largest representable pixel.
   function automatic logic [DATA_W-1:0] sat_pix(input logic [ACC_W:0] v);
      if (v > PIX_MAX) return {DATA_W{1'b1}};
      return v[DATA_W-1:0];
   endfunction

   // Divide a block sum by F*F = 2^(2k), rounding when enabled.
   function automatic logic [DATA_W-1:0] scale_pix(input logic [ACC_W-1:0] a,
                                                   input logic [1:0] k);
      logic [ACC_W:0] v;
      v = {1'b0, a};
`ifdef ROUND_NEAREST_EN
      case (k)
         2'd1:    v = v + (ACC_W+1)'(2);
         2'd2:    v = v + (ACC_W+1)'(8);
         default: v = v;
      endcase
`endif
      v = v >> {k, 1'b0};
      return sat_pix(v);
   endfunction

   // Geometry and address stepping derived from the latched factor.
   always_comb begin
      f_m1     = 2'd0;
      nsq_m1   = 4'd0;
      ow_m1    = XW'(IMG_W - 1);
      oh_m1    = YW'(IMG_H - 1);
      row_wrap = '0;
      case (k_q)
         2'd1: begin
            f_m1     = 2'd1;
            nsq_m1   = 4'd3;
            ow_m1    = XW'(IMG_W / 2 - 1);
            oh_m1    = YW'(IMG_H / 2 - 1);
            row_wrap = RD_AW'(IMG_W);
         end
         2'd2: begin
            f_m1     = 2'd3;
            nsq_m1   = 4'd15;
            ow_m1    = XW'(IMG_W / 4 - 1);
            oh_m1    = YW'(IMG_H / 4 - 1);
            row_wrap = RD_AW'(3 * IMG_W);
         end
         default: ;
      endcase
      // Within a block: next column, or back to dx=0 on the next row.
      if (dx == f_m1)
         next_rd = rd_addr_q + RD_AW'(IMG_W) - RD_AW'(f_m1);
      else
         next_rd = rd_addr_q + RD_AW'(1);
      // Between blocks: step right by F, or down to the next block row.
      next_base = blk_base + RD_AW'(f_m1) + RD_AW'(1);
      if (bx == ow_m1)
         next_base = next_base + row_wrap;
      last_blk = (bx == ow_m1) && (by == oh_m1);
      acc_in   = first_p1 ? ACC_W'(bus.rd_data) : acc + ACC_W'(bus.rd_data);
   end

   // Run-control FSM with registered read/write strobes and status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         k_q       <= 2'd0;
         rd_cnt    <= 4'd0;
         dx        <= 2'd0;
         bx        <= '0;
         by        <= '0;
         blk_base  <= '0;
         out_idx   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  k_q       <= (bus.factor_log2 == 2'd3) ? 2'd2 : bus.factor_log2;
                  bx        <= '0;
                  by        <= '0;
                  blk_base  <= '0;
                  out_idx   <= '0;
                  rd_cnt    <= 4'd0;
                  dx        <= 2'd0;
                  rd_addr_q <= '0;
                  rd_en_q   <= 1'b1;
                  busy_q    <= 1'b1;
                  state     <= READ;
               end
            end
            READ: begin
               if (rd_cnt == nsq_m1) begin
                  rd_en_q <= 1'b0;
                  state   <= DRAIN;
               end else begin
                  rd_cnt    <= rd_cnt + 4'd1;
                  dx        <= (dx == f_m1) ? 2'd0 : dx + 2'd1;
                  rd_addr_q <= next_rd;
               end
            end
            DRAIN: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= out_idx;
               wr_data_q <= scale_pix(acc_in, k_q);
               state     <= WRITE;
            end
            WRITE: begin
               wr_en_q <= 1'b0;
               out_idx <= out_idx + WR_AW'(1);
               if (last_blk) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  if (bx == ow_m1) begin
                     bx <= '0;
                     by <= by + YW'(1);
                  end else begin
                     bx <= bx + XW'(1);
                  end
                  blk_base  <= next_base;
                  rd_addr_q <= next_base;
                  rd_cnt    <= 4'd0;
                  dx        <= 2'd0;
                  rd_en_q   <= 1'b1;
                  state     <= READ;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Read-return pipeline: tag returning data and accumulate the block sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_p1 <= 1'b0;
         first_p1  <= 1'b0;
         acc       <= '0;
      end else begin
         rd_vld_p1 <= rd_en_q;
         first_p1  <= rd_en_q && (rd_cnt == 4'd0);
         if (rd_vld_p1)
            acc <= acc_in;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_block_avg_scaler.sv
// Bench for block_avg_scaler on an 8x4 image: a table of runs over several
// factors and pixel patterns, plus hand-written corner sequences. Expected
// reads and writes are queued when a run is started and popped as the DUT
// drives its strobes.
module tb_block_avg_scaler;

   localparam int DW = 8;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int AW = 5;
   localparam int NPIX = W * H;

   logic clk = 1'b0;
   logic rst_n;

   block_avg_scaler_if #(.DATA_W(DW), .RD_AW(AW), .WR_AW(AW)) bus ();

   block_avg_scaler #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .RD_AW(AW), .WR_AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] src [NPIX];
   logic [DW-1:0] dst [NPIX];

   // Source RAM: one-cycle read latency, garbage when no read was issued.
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= src[bus.rd_addr];
      else           bus.rd_data <= DW'($urandom);
   end

   // Destination RAM.
   always @(posedge clk) begin
      if (bus.wr_en) dst[bus.wr_addr] <= bus.wr_data;
   end

   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   int wr_cnt, done_cnt, done_cyc, last_wr, gap, first_wd, first_wa;
   int exp_rd[$];
   int exp_wa[$];
   int exp_wd[$];
   int rd_log[$];

   typedef struct {
      logic [1:0] fl;
      int         pat;
      int         exp_n;
      int         exp_len;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   function automatic logic [31:0] outs_word();
      return 32'({bus.busy, bus.done, bus.rd_en, bus.wr_en,
                  bus.rd_addr, bus.wr_addr, bus.wr_data});
   endfunction

   // One clock: sample DUT outputs on the falling edge and score them.
   task automatic cyc();
      int e;
      @(negedge clk);
      cyc_n++;
      if (bus.rd_en) begin
         rd_log.push_back(32'(bus.rd_addr));
         if (exp_rd.size() == 0) chk("rd_unexpected", 32'(bus.rd_addr), 32'hFFFF_FFFF);
         else begin
            e = exp_rd.pop_front();
            chk("rd_addr", 32'(bus.rd_addr), e);
         end
      end
      if (bus.wr_en) begin
         wr_cnt++;
         chk("rd_wr_overlap", 32'(bus.rd_en), 0);
         if (last_wr >= 0) chk("wr_spacing", cyc_n - last_wr, gap);
         last_wr = cyc_n;
         if (first_wd < 0) begin
            first_wd = 32'(bus.wr_data);
            first_wa = 32'(bus.wr_addr);
         end
         if (exp_wa.size() == 0) chk("wr_unexpected", 32'(bus.wr_addr), 32'hFFFF_FFFF);
         else begin
            e = exp_wa.pop_front();
            chk("wr_addr", 32'(bus.wr_addr), e);
            e = exp_wd.pop_front();
            chk("wr_data", 32'(bus.wr_data), e);
         end
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc_n;
         chk("busy_at_done", 32'(bus.busy), 0);
      end
   endtask

   task automatic load_pat(input int p);
      for (int i = 0; i < NPIX; i++) begin
         case (p)
            0:       src[i] = DW'(i);
            2:       src[i] = DW'(255);
            default: src[i] = DW'($urandom_range(0, 255));
         endcase
      end
      if (p == 3) begin
         src[0] = 8'd10; src[1] = 8'd11; src[W] = 8'd12; src[W+1] = 8'd13;
      end
   endtask

   // Reference model: expected read order and averaged writes for factor 2^k.
   task automatic build_model(input int k);
      int f, ow, oh, a, sum, d;
      f = 1 << k; ow = W >> k; oh = H >> k;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      for (int by = 0; by < oh; by++)
         for (int bx = 0; bx < ow; bx++) begin
            sum = 0;
            for (int dy = 0; dy < f; dy++)
               for (int dx = 0; dx < f; dx++) begin
                  a = (by * f + dy) * W + bx * f + dx;
                  exp_rd.push_back(a);
                  sum += int'(src[a]);
               end
`ifdef ROUND_NEAREST_EN
            if (k > 0) sum += 1 << (2 * k - 1);
`endif
            d = sum >> (2 * k);
            if (d > 255) d = 255;
            exp_wa.push_back(by * ow + bx);
            exp_wd.push_back(d);
         end
      gap = f * f + 2;
   endtask

   task automatic clear_run_state();
      wr_cnt = 0; done_cnt = 0; done_cyc = -1; last_wr = -1;
      first_wd = -1; first_wa = -1;
      rd_log.delete();
   endtask

   // One full run; starts in the cycle after the previous call returned.
   task automatic run_k(input logic [1:0] fl, input int poke, output int len, output int nwr);
      int k, s;
      k = (fl == 2'd3) ? 2 : int'(fl);
      build_model(k);
      clear_run_state();
      cyc();
      s = cyc_n;
      bus.start = 1'b1;
      bus.factor_log2 = fl;
      cyc();
      bus.start = 1'b0;
      bus.factor_log2 = 2'($urandom);
      chk("busy_after_start", 32'(bus.busy), 1);
      for (int i = 0; i < 600 && done_cnt == 0; i++) begin
         bus.start = (i == poke);
         if (i == poke) bus.factor_log2 = 2'd0;
         cyc();
      end
      bus.start = 1'b0;
      if (done_cnt == 0) chk("done_timeout", 0, 1);
      len = done_cyc - s + 1;
      nwr = wr_cnt;
      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wa.size(), 0);
   endtask

   initial begin
      int len, n, bad;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.factor_log2 = 2'd0;
      load_pat(0);
      clear_run_state();
      repeat (3) cyc();
      chk("reset_outputs", outs_word(), 0);
      rst_n = 1'b1;

      vecs[0] = '{fl: 2'd0, pat: 0, exp_n: 32, exp_len: 98};
      vecs[1] = '{fl: 2'd1, pat: 3, exp_n: 8,  exp_len: 50};
      vecs[2] = '{fl: 2'd2, pat: 2, exp_n: 2,  exp_len: 38};
      vecs[3] = '{fl: 2'd3, pat: 1, exp_n: 2,  exp_len: 38};
      vecs[4] = '{fl: 2'd1, pat: 1, exp_n: 8,  exp_len: 50};
      vecs[5] = '{fl: 2'd0, pat: 2, exp_n: 32, exp_len: 98};
      vecs[6] = '{fl: 2'd2, pat: 1, exp_n: 2,  exp_len: 38};

      for (int v = 0; v < 7; v++) begin
         load_pat(vecs[v].pat);
         run_k(vecs[v].fl, -1, len, n);
         chk($sformatf("vec%0d_writes", v), n, vecs[v].exp_n);
         chk($sformatf("vec%0d_run_len", v), len, vecs[v].exp_len);
         if (v == 0) begin
            bad = 0;
            for (int i = 0; i < NPIX; i++) if (dst[i] !== src[i]) bad++;
            chk("copy_dst_mismatches", bad, 0);
         end
      end

      // Half average on a known first block.
      load_pat(3);
      run_k(2'd1, -1, len, n);
`ifdef ROUND_NEAREST_EN
      chk("half_first_data", first_wd, 12);
`else
      chk("half_first_data", first_wd, 11);
`endif
      chk("half_first_addr", first_wa, 0);
      chk("half_rd0", rd_log[0], 0);
      chk("half_rd1", rd_log[1], 1);
      chk("half_rd2", rd_log[2], W);
      chk("half_rd3", rd_log[3], W + 1);

      // Clamped factor with an ignored second start mid-run.
      load_pat(1);
      run_k(2'd3, 7, len, n);
      chk("clamp_run_len", len, 38);
      chk("clamp_writes", n, 2);
      repeat (3) cyc();
      chk("clamp_single_done", done_cnt, 1);

      // Back-to-back: k=1 then k=0 starting the cycle after done.
      load_pat(1);
      run_k(2'd1, -1, len, n);
      run_k(2'd0, -1, len, n);
      chk("b2b_run_len", len, 98);
      chk("b2b_first_rd", rd_log[0], 0);
      chk("b2b_writes", n, 32);

      // Reset in the middle of block 5.
      load_pat(1);
      build_model(1);
      clear_run_state();
      cyc();
      bus.start = 1'b1;
      bus.factor_log2 = 2'd1;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 200 && wr_cnt < 5; i++) cyc();
      chk("abort_reached_blk5", wr_cnt, 5);
      cyc();
      cyc();
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", outs_word(), 0);
      repeat (3) cyc();
      chk("abort_no_done", done_cnt, 0);
      rst_n = 1'b1;
      run_k(2'd1, -1, len, n);
      chk("after_abort_len", len, 50);
      chk("after_abort_first_addr", first_wa, 0);
      chk("after_abort_first_rd", rd_log[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/block_avg_scaler.md
# block_avg_scaler

Parametrised block-averaging downscaler for the frame-buffer pipeline. It reads a source image of IMG_W × IMG_H pixels from a synchronous-read RAM and, for each F × F block (F = 1, 2 or 4), writes the averaged pixel to a destination RAM in raster order. Each run is started by a one-cycle pulse from the zoom controller, and completion is reported with a done pulse. It succeeds the fixed 160×120 / 8-bit averager and adds run control, a 4×4 true average, sequential block reads and configurable rounding.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 160, source width in pixels; must be a multiple of 4
- IMG_H, 120, source height in pixels; must be a multiple of 4
- RD_AW, 15, source address width; must satisfy 2^RD_AW ≥ IMG_W·IMG_H
- WR_AW, 15, destination address width; must satisfy 2^WR_AW ≥ IMG_W·IMG_H

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a run; sampled only in IDLE
- factor_log2  in  2  k, where F = 2^k; latched on start; a value of 3 is clamped to 2
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the run completes
- rd_en  out  1  source read strobe
- rd_addr  out  RD_AW  source address; data returns one cycle later
- rd_data  in  DATA_W  source data, valid the cycle after rd_en
- wr_en  out  1  destination write strobe
- wr_addr  out  WR_AW  destination address
- wr_data  out  DATA_W  averaged pixel

## Operation
- Output geometry: OW = IMG_W>>k, OH = IMG_H>>k, N = OW·OH.
- States:
  - IDLE: on start, go to READ; latch k; clear the block counters bx and by.
  - READ: F² cycles.
  - DRAIN: 1 cycle.
  - WRITE: 1 cycle.
  - From WRITE: go to READ for the next block, or to DONE after the last block.
  - DONE: 1 cycle, then IDLE.
- READ issues F² back-to-back reads.
  - Order inside a block is dy outer, dx inner.
  - rd_addr = (by·F+dy)·IMG_W + bx·F + dx.
- Accumulator is DATA_W+4 bits.
  - The first returned sample of a block loads the accumulator; each later sample adds to it.
  - The last sample is accumulated during DRAIN.
- WRITE: wr_en=1, wr_addr = by·OW+bx, wr_data = acc >> 2k (rounding per Configuration).
- Block traversal: bx increments to OW−1, then wraps to 0 and by increments. The block with by = OH−1 and bx = OW−1 is the last.
- start while busy is ignored. factor_log2 changes mid-run have no effect.
- rd_data is ignored outside the cycle after rd_en.
- Reset values: all outputs 0, state IDLE, counters and accumulator 0.
- rst_n asserted mid-run aborts immediately.
  - No done pulse is produced.
  - Destination contents written so far are left as they are.

## Timing
- start sampled high in IDLE at cycle t → busy=1 and the first rd_en at t+1.
- Per output pixel: rd_en high for F² consecutive cycles (t0 … t0+F²−1), DRAIN at t0+F², wr_en at t0+F²+1. The next block's first rd_en is at t0+F²+2.
- Throughput: F²+2 cycles per output pixel.
  - k=0: 3 cycles per pixel.
  - k=1: 6 cycles per pixel.
  - k=2: 18 cycles per pixel.
- done=1 and busy=0 in the cycle after the last wr_en. A new start is accepted from the following cycle.
- Total run length from start to done = N·(F²+2)+2 cycles.
  - 160×120 at k=1: 28802 cycles.
- wr_en is never high in the same cycle as rd_en.
- The accumulator cannot overflow: maximum sum 16·(2^DATA_W−1) fits in DATA_W+4 bits.

## Configuration
- ROUND_NEAREST_EN defined: for k>0, wr_data = (acc + 2^(2k−1)) >> 2k.
  - The result saturates to 2^DATA_W−1; because the inputs are bounded it can never exceed that, but the saturation is still implemented.
- Undefined: truncating division, wr_data = acc >> 2k.
- k=0 is an identity copy in both builds.

## Test plan
- Copy: k=0, 8×4 image holding values 0…31 → 32 writes, wr_data == source, wr_addr 0…31, each write 3 cycles apart, done once.
- Half average: k=1, first block = {10,11,12,13} → wr_data 11 (truncate) or 12 (ROUND_NEAREST_EN); wr_addr 0; rd_addr sequence 0, 1, IMG_W, IMG_W+1.
- Quarter saturation: k=2, all source pixels 255 → every wr_data 255, N = (IMG_W/4)·(IMG_H/4) writes, run length N·18+2 cycles.
- Clamp and ignore: factor_log2=3 with start → behaves exactly as k=2; a second start pulsed mid-run → no restart and exactly one done.
- Reset mid-run: rst_n low during block 5 → all outputs 0 within the same cycle, no done; a new start then runs cleanly from wr_addr 0.
- Back-to-back runs: start in the cycle after done with k changed 1→0 → second run uses k=0 geometry, and rd_addr restarts at 0.
